lock_code_tx: RTL and testbench
===============================

// Module: lock_code_tx
// PURPOSE
//  Serial code transmitter for the digital lock: drives the lock's 1-bit w input.
//  - Accepts a CODE_W-bit code word on a start pulse; shifts it out MSB-first, one bit per sys_clk.
//  - Pulses done when finished.
//  - Optional: monitors the lock's F output and reports pass/fail.
//  - Sits between the test/keypad controller and the lock FSM.
// PARAMETERS
//  CODE_W     8  code word width in bits (>=1)
//  CNT_W      4  bit-counter width; must satisfy 2**CNT_W >= CODE_W
//  CHECK_WIN  3  cycles F is sampled after last bit (used only with UNLOCK_CHECK_EN)
// PORTS
//  sys_clk  in   1        system clock, all logic on rising edge
//  reset    in   1        asynchronous, active-high reset
//  start    in   1        request; sampled only in IDLE
//  code     in   CODE_W   code word, captured on accepted start
//  w_out    out  1        serial bit to lock w input (registered)
//  w_valid  out  1        1 while w_out carries a code bit (state==SEND)
//  busy     out  1        1 in any state other than IDLE
//  done     out  1        one-cycle pulse in DONE
//  state    out  3        FSM state: IDLE=0, SEND=1, CHECK=2, DONE=3
//  f_in     in   1        lock F output (UNLOCK_CHECK_EN only)
//  pass     out  1        F seen high in check window (UNLOCK_CHECK_EN only)
//  fail     out  1        window expired with F low (UNLOCK_CHECK_EN only)
// BEHAVIOUR
//  Reset (async, immediate):
//  - w_out, w_valid, busy, done, pass and fail go to 0.
//  - Shift register and counter go to 0; state goes to IDLE.
//  - Reset mid-operation aborts transmission with no done pulse.
//  IDLE: start=1 at edge k:
//  - shreg<=code; w_out<=code[CODE_W-1]; cnt<=CODE_W-1; pass,fail<=0; state<=SEND.
//  - start=0: stay in IDLE, w_out holds.
//  SEND, at each edge:
//  - cnt==0: leave to CHECK (macro on) or DONE (macro off).
//  - Otherwise: shift left, w_out<=next bit, cnt<=cnt-1.
//  SEND timing:
//  - code[i] is on w_out in cycle k+1+(CODE_W-1-i).
//  - SEND lasts exactly CODE_W cycles.
//  - w_valid = (state==SEND).
//  CHECK (macro only):
//  - Window counter starts at CHECK_WIN-1.
//  - f_in=1 sampled: pass<=1, go to DONE.
//  - Window counter reaches 0 with f_in=0: fail<=1, go to DONE.
//  - CHECK lasts 1..CHECK_WIN cycles.
//  DONE:
//  - done=1 for exactly one cycle, then IDLE.
//  - Minimum gap between transmissions: with start held high, one IDLE cycle between DONE and the next SEND.
//  w_out after the last bit:
//  - Holds the last transmitted bit through CHECK, DONE and IDLE until the next accepted start.
//  - This keeps the lock parked in its final state; it never returns to a default level.
//  Ignored inputs:
//  - start outside IDLE is ignored.
//  - code changes after capture have no effect.
//  pass/fail:
//  - Mutually exclusive.
//  - Held until the next accepted start or reset.
//  Latency (macro off): done high in cycle k+1+CODE_W.
//  CODE_W=1: SEND lasts one cycle; cnt starts at 0.
// CONFIGURATION
//  UNLOCK_CHECK_EN defined:
//  - CHECK state, f_in, pass and fail are present.
//  UNLOCK_CHECK_EN undefined:
//  - No f_in/pass/fail ports; SEND goes straight to DONE.
//  - State encoding 2 is never produced; CHECK_WIN is unused.
// TESTING
//  1 CODE_W=8, code=8'h0F, start 1 cycle -> w_out 0,0,0,0,1,1,1,1 on cycles k+1..k+8, w_valid=1 for those 8 cycles, done=1 at k+9, w_out stays 1 after.
//  2 Start 8'h33, then start=1 with code=8'hFF at k+3 -> output remains 0,0,1,1,0,0,1,1; no second transmission.
//  3 Reset asserted mid-SEND (between clock edges) -> all outputs 0 and state=0 immediately, before the next edge; next start with 8'hF0 sends full 1,1,1,1,0,0,0,0.
//  4 start held high, code=8'hAA -> SEND(8), DONE(1), IDLE(1), SEND(8) repeating; busy low only in the IDLE cycle.
//  5 Macro on, lock model on w_out:
//    - code 8'h0F -> f_in rises within CHECK_WIN -> pass=1, fail=0, done pulses.
//    - code 8'h5A -> f_in stays 0 -> fail=1 after 3 CHECK cycles.
//  6 CODE_W=1, code=1'b1 -> w_valid high 1 cycle, done at k+2 (macro off), w_out=1 held.

Source files
------------

// File: rtl/lock_code_tx.sv
// Serial code transmitter for the digital lock: shifts a captured code word out MSB-first on w_out.
// Define UNLOCK_CHECK_EN to add the F-monitor window (CHECK state, f_in, pass, fail).
module lock_code_tx #(
    parameter int CODE_W    = 8,
    parameter int CNT_W     = 4,
    parameter int CHECK_WIN = 3
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
    output logic              w_out,
    output logic              w_valid,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state
`ifdef UNLOCK_CHECK_EN
    ,
    input  logic              f_in,
    output logic              pass,
    output logic              fail
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3
    } state_t;

    if (CODE_W < 1 || (2 ** CNT_W) < CODE_W || CHECK_WIN < 1) begin : g_bad_params
        $error("lock_code_tx: invalid CODE_W/CNT_W/CHECK_WIN combination");
    end

    state_t              r_state;
    logic [CODE_W-1:0]   r_shreg;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_w_out;
    logic                r_w_valid;
    logic                r_busy;
    logic                r_done;
    logic [CODE_W-1:0]   w_shifted;

    // Shifting through a full-width wire keeps CODE_W=1 legal (no negative bit index).
    assign w_shifted = r_shreg << 1;

`ifdef UNLOCK_CHECK_EN
    localparam int WIN_W = (CHECK_WIN > 1) ? $clog2(CHECK_WIN) : 1;

    logic [WIN_W-1:0]    r_win;
    logic                r_pass;
    logic                r_fail;
`endif

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_w_out   <= 1'b0;
            r_w_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef UNLOCK_CHECK_EN
            r_win     <= '0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shreg   <= code;
                        r_w_out   <= code[CODE_W-1];
                        r_cnt     <= CNT_W'(CODE_W - 1);
                        r_w_valid <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_SEND;
`ifdef UNLOCK_CHECK_EN
                        r_pass    <= 1'b0;
                        r_fail    <= 1'b0;
`endif
                    end
                end

                S_SEND: begin
                    if (r_cnt == '0) begin
                        // w_out is left on the last bit so the lock stays parked.
                        r_w_valid <= 1'b0;
`ifdef UNLOCK_CHECK_EN
                        r_win     <= WIN_W'(CHECK_WIN - 1);
                        r_state   <= S_CHECK;
`else
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
`endif
                    end else begin
                        r_shreg <= w_shifted;
                        r_w_out <= w_shifted[CODE_W-1];
                        r_cnt   <= r_cnt - CNT_W'(1);
                    end
                end

`ifdef UNLOCK_CHECK_EN
                S_CHECK: begin
                    if (f_in) begin
                        r_pass  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_win == '0) begin
                        r_fail  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_win <= r_win - WIN_W'(1);
                    end
                end
`endif

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_w_valid <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign w_out   = r_w_out;
    assign w_valid = r_w_valid;
    assign busy    = r_busy;
    assign done    = r_done;
    assign state   = r_state;

`ifdef UNLOCK_CHECK_EN
    assign pass = r_pass;
    assign fail = r_fail;
`endif

endmodule

// File: tb/tb_lock_code_tx.sv
// Directed bench for lock_code_tx: an 8-bit instance plus a CODE_W=1 instance.
// With UNLOCK_CHECK_EN defined, a small lock model drives f_in for the pass/fail scenario.
module tb_lock_code_tx;

    localparam int CW = 8;
`ifdef UNLOCK_CHECK_EN
    localparam int CHK = 3;
`else
    localparam int CHK = 0;
`endif
    localparam int FR = CW + CHK + 2;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       start   = 1'b0;
    logic [7:0] code    = 8'h00;
    logic       w_out, w_valid, busy, done;
    logic [2:0] state;

    logic       start1  = 1'b0;
    logic [0:0] code1   = 1'b0;
    logic       w_out1, w_valid1, busy1, done1;
    logic [2:0] state1;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef UNLOCK_CHECK_EN
    logic       f_in, pass, fail;
    logic       f_in1 = 1'b0;
    logic       pass1, fail1;
    logic       lock_en = 1'b0;
    logic [7:0] lock_sr;

    always @(posedge sys_clk) if (w_valid) lock_sr <= {lock_sr[6:0], w_out};
    assign f_in = lock_en && (lock_sr == 8'h0F);
`endif

    lock_code_tx #(.CODE_W(8), .CNT_W(4), .CHECK_WIN(3)) dut (
        .sys_clk(sys_clk), .reset(reset), .start(start), .code(code),
        .w_out(w_out), .w_valid(w_valid), .busy(busy), .done(done), .state(state)
`ifdef UNLOCK_CHECK_EN
        , .f_in(f_in), .pass(pass), .fail(fail)
`endif
    );

    lock_code_tx #(.CODE_W(1), .CNT_W(1), .CHECK_WIN(3)) dut1 (
        .sys_clk(sys_clk), .reset(reset), .start(start1), .code(code1),
        .w_out(w_out1), .w_valid(w_valid1), .busy(busy1), .done(done1), .state(state1)
`ifdef UNLOCK_CHECK_EN
        , .f_in(f_in1), .pass(pass1), .fail(fail1)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_chk++; if ({w_out, w_valid, busy, done, state} !== 7'b0) begin n_fail++; $display("FAIL reset_outs got=%b exp=%b", {w_out, w_valid, busy, done, state}, 7'b0); end
        n_chk++; if ({w_out1, w_valid1, busy1, done1, state1} !== 7'b0) begin n_fail++; $display("FAIL reset_outs_w1 got=%b exp=%b", {w_out1, w_valid1, busy1, done1, state1}, 7'b0); end
`ifdef UNLOCK_CHECK_EN
        n_chk++; if ({pass, fail} !== 2'b00) begin n_fail++; $display("FAIL reset_passfail got=%b exp=00", {pass, fail}); end
`endif
        step();
        step();
        reset = 1'b0;
        step();
        n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_idle state=%0d exp=0", state); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [7:0] exp_bits;
        exp_bits = 8'b0000_1111;
        code = 8'h0F; start = 1'b1;
        step();
        start = 1'b0; code = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            n_chk++; if (w_out !== exp_bits[7-i]) begin n_fail++; $display("FAIL basic_bit%0d w_out=%b exp=%b", i, w_out, exp_bits[7-i]); end
            n_chk++; if ({w_valid, busy, done, state} !== {3'b110, 3'd1}) begin n_fail++; $display("FAIL basic_send%0d got=%b exp=%b", i, {w_valid, busy, done, state}, {3'b110, 3'd1}); end
            step();
        end
        for (int c = 0; c < CHK; c++) begin
            n_chk++; if ({w_valid, busy, done, state} !== {3'b010, 3'd2}) begin n_fail++; $display("FAIL basic_check%0d got=%b exp=%b", c, {w_valid, busy, done, state}, {3'b010, 3'd2}); end
            step();
        end
        n_chk++; if ({w_out, w_valid, busy, done, state} !== {4'b1011, 3'd3}) begin n_fail++; $display("FAIL basic_done got=%b exp=%b", {w_out, w_valid, busy, done, state}, {4'b1011, 3'd3}); end
        step();
        n_chk++; if ({w_out, w_valid, busy, done, state} !== {4'b1000, 3'd0}) begin n_fail++; $display("FAIL basic_idle got=%b exp=%b", {w_out, w_valid, busy, done, state}, {4'b1000, 3'd0}); end
        step();
        step();
        n_chk++; if (w_out !== 1'b1) begin n_fail++; $display("FAIL basic_hold w_out=%b exp=1", w_out); end
        $display("test_basic code=0F done");
    endtask

    task automatic test_ignore_start();
        logic [7:0] exp_bits;
        exp_bits = 8'b0011_0011;
        code = 8'h33; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin start = 1'b1; code = 8'hFF; end
            else start = 1'b0;
            n_chk++; if (w_out !== exp_bits[7-i]) begin n_fail++; $display("FAIL ignore_bit%0d w_out=%b exp=%b", i, w_out, exp_bits[7-i]); end
            step();
        end
        start = 1'b0;
        repeat (CHK) step();
        n_chk++; if ({done, state} !== {1'b1, 3'd3}) begin n_fail++; $display("FAIL ignore_done got=%b exp=%b", {done, state}, {1'b1, 3'd3}); end
        for (int j = 0; j < 3; j++) begin
            step();
            n_chk++; if ({w_out, w_valid, busy, state} !== {3'b100, 3'd0}) begin n_fail++; $display("FAIL ignore_idle%0d got=%b exp=%b", j, {w_out, w_valid, busy, state}, {3'b100, 3'd0}); end
        end
        $display("test_ignore_start code=33 done");
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_bits;
        exp_bits = 8'b1111_0000;
        code = 8'hAA; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #3;
        reset = 1'b1;
        #1;
        n_chk++; if ({w_out, w_valid, busy, done, state} !== 7'b0) begin n_fail++; $display("FAIL midreset_outs got=%b exp=%b", {w_out, w_valid, busy, done, state}, 7'b0); end
        #1;
        reset = 1'b0;
        step();
        n_chk++; if ({done, state} !== 4'b0) begin n_fail++; $display("FAIL midreset_nodone got=%b exp=0000", {done, state}); end
        code = 8'hF0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_chk++; if ({w_out, w_valid} !== {exp_bits[7-i], 1'b1}) begin n_fail++; $display("FAIL midreset_bit%0d got=%b exp=%b", i, {w_out, w_valid}, {exp_bits[7-i], 1'b1}); end
            step();
        end
        repeat (CHK) step();
        n_chk++; if ({w_out, done, state} !== {2'b01, 3'd3}) begin n_fail++; $display("FAIL midreset_done got=%b exp=%b", {w_out, done, state}, {2'b01, 3'd3}); end
        step();
        $display("test_reset_mid code=F0 done");
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat;
        int p;
        pat = 8'hAA;
        code = 8'hAA; start = 1'b1;
        step();
        for (int j = 0; j < 2 * FR; j++) begin
            p = j % FR;
            if (p < CW) begin
                n_chk++; if ({w_out, busy, done, state} !== {pat[7-p], 2'b10, 3'd1}) begin n_fail++; $display("FAIL b2b_send j=%0d got=%b exp=%b", j, {w_out, busy, done, state}, {pat[7-p], 2'b10, 3'd1}); end
            end else if (p < CW + CHK) begin
                n_chk++; if ({busy, done, state} !== {2'b10, 3'd2}) begin n_fail++; $display("FAIL b2b_check j=%0d got=%b exp=%b", j, {busy, done, state}, {2'b10, 3'd2}); end
            end else if (p == CW + CHK) begin
                n_chk++; if ({busy, done, state} !== {2'b11, 3'd3}) begin n_fail++; $display("FAIL b2b_done j=%0d got=%b exp=%b", j, {busy, done, state}, {2'b11, 3'd3}); end
            end else begin
                n_chk++; if ({busy, done, state} !== {2'b00, 3'd0}) begin n_fail++; $display("FAIL b2b_idle j=%0d got=%b exp=%b", j, {busy, done, state}, {2'b00, 3'd0}); end
            end
            step();
        end
        start = 1'b0;
        repeat (FR + 2) step();
        n_chk++; if ({busy, state} !== 4'b0) begin n_fail++; $display("FAIL b2b_settle got=%b exp=0000", {busy, state}); end
        $display("test_back_to_back code=AA done");
    endtask

`ifdef UNLOCK_CHECK_EN
    task automatic test_check();
        lock_en = 1'b1;
        code = 8'h0F; start = 1'b1;
        step();
        start = 1'b0;
        n_chk++; if ({pass, fail} !== 2'b00) begin n_fail++; $display("FAIL chk_clear got=%b exp=00", {pass, fail}); end
        repeat (7) step();
        step();
        n_chk++; if ({f_in, state} !== {1'b1, 3'd2}) begin n_fail++; $display("FAIL chk_window got=%b exp=%b", {f_in, state}, {1'b1, 3'd2}); end
        step();
        n_chk++; if ({pass, fail, done, state} !== {3'b101, 3'd3}) begin n_fail++; $display("FAIL chk_pass got=%b exp=%b", {pass, fail, done, state}, {3'b101, 3'd3}); end
        step();
        n_chk++; if ({pass, fail, state} !== {2'b10, 3'd0}) begin n_fail++; $display("FAIL chk_pass_hold got=%b exp=%b", {pass, fail, state}, {2'b10, 3'd0}); end
        code = 8'h5A; start = 1'b1;
        step();
        start = 1'b0;
        n_chk++; if ({pass, fail} !== 2'b00) begin n_fail++; $display("FAIL chk_clear2 got=%b exp=00", {pass, fail}); end
        repeat (7) step();
        for (int c = 0; c < 3; c++) begin
            step();
            n_chk++; if ({fail, done, state} !== {2'b00, 3'd2}) begin n_fail++; $display("FAIL chk_win%0d got=%b exp=%b", c, {fail, done, state}, {2'b00, 3'd2}); end
        end
        step();
        n_chk++; if ({pass, fail, done, state} !== {3'b011, 3'd3}) begin n_fail++; $display("FAIL chk_fail got=%b exp=%b", {pass, fail, done, state}, {3'b011, 3'd3}); end
        step();
        lock_en = 1'b0;
        $display("test_check codes=0F,5A done");
    endtask
`endif

    task automatic test_code_w1();
        code1 = 1'b1; start1 = 1'b1;
        step();
        start1 = 1'b0;
        n_chk++; if ({w_out1, w_valid1, busy1, done1, state1} !== {4'b1110, 3'd1}) begin n_fail++; $display("FAIL w1_send got=%b exp=%b", {w_out1, w_valid1, busy1, done1, state1}, {4'b1110, 3'd1}); end
        step();
        repeat (CHK) step();
        n_chk++; if ({w_out1, w_valid1, busy1, done1, state1} !== {4'b1011, 3'd3}) begin n_fail++; $display("FAIL w1_done got=%b exp=%b", {w_out1, w_valid1, busy1, done1, state1}, {4'b1011, 3'd3}); end
        step();
        n_chk++; if ({w_out1, w_valid1, busy1, done1, state1} !== {4'b1000, 3'd0}) begin n_fail++; $display("FAIL w1_idle got=%b exp=%b", {w_out1, w_valid1, busy1, done1, state1}, {4'b1000, 3'd0}); end
`ifdef UNLOCK_CHECK_EN
        n_chk++; if ({pass1, fail1} !== 2'b01) begin n_fail++; $display("FAIL w1_fail got=%b exp=01", {pass1, fail1}); end
`endif
        $display("test_code_w1 code=1 done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
`ifdef UNLOCK_CHECK_EN
        test_check();
`endif
        test_code_w1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
